// File: rtl/tq_qp_ctrl.sv
// tq_qp_ctrl: per-CU quantization-parameter sequencer.
// Keeps the slice QP predictor, applies each CU's delta-QP with modular wrap,
// then derives qp/6 and qp%6 by repeated subtraction before presenting
// {qp, div, mod} to the quant datapath over a valid/ready handshake.
module tq_qp_ctrl #(
   parameter int MAX_QP = 51,
   parameter int QP_W   = 6,
   parameter int DQP_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slice_start_i,
   input  logic [QP_W-1:0]  slice_qp_i,
   input  logic             cu_valid_i,
   output logic             cu_ready_o,
   input  logic             cu_dqp_en_i,
   input  logic [DQP_W-1:0] cu_dqp_i,
   output logic             qp_valid_o,
   input  logic             qp_ready_i,
   output logic [QP_W-1:0]  qp_o,
   output logic [3:0]       qp_div_o,
   output logic [2:0]       qp_mod_o,
   output logic             dqp_err_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] cu_cnt_o
);

   localparam int SUM_W   = QP_W + 3;
   localparam int DQP_MIN = -((MAX_QP + 1) / 2);
   localparam int DQP_MAX = MAX_QP / 2;
   localparam logic [QP_W-1:0]         MAX_QP_V = QP_W'(MAX_QP);
   localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(MAX_QP);
   localparam logic signed [SUM_W-1:0] MOD_S    = SUM_W'(MAX_QP + 1);
   localparam logic [QP_W-1:0]         SIX      = QP_W'(6);

   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

   state_t                  state, state_nxt;
   logic [QP_W-1:0]         pred;
   logic [QP_W-1:0]         rem;
   logic [QP_W-1:0]         slice_clamped;
   logic [QP_W-1:0]         pred_eff;
   logic [QP_W-1:0]         qp_new;
   logic signed [DQP_W-1:0] dqp_s;
   logic signed [SUM_W-1:0] d_ext;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] wrapped;
   logic                    dqp_ok;
   logic                    cu_hs;
   logic                    out_hs;

   assign cu_ready_o = (state == IDLE);
   assign qp_valid_o = (state == OUT);
   assign busy_o     = (state != IDLE);
   assign cu_hs      = cu_valid_i & cu_ready_o;
   assign out_hs     = qp_valid_o & qp_ready_i;

   // Resolve the CU QP: a slice start in the same cycle overrides the stored
   // predictor, out-of-range deltas are treated as zero, and the sum wraps
   // modulo MAX_QP+1 in either direction.
   always_comb begin
      slice_clamped = (slice_qp_i > MAX_QP_V) ? MAX_QP_V : slice_qp_i;
      pred_eff      = slice_start_i ? slice_clamped : pred;
      dqp_s         = $signed(cu_dqp_i);
      dqp_ok        = (int'(dqp_s) >= DQP_MIN) && (int'(dqp_s) <= DQP_MAX);
      d_ext         = '0;
      if (cu_dqp_en_i && dqp_ok)
         d_ext = {{(SUM_W-DQP_W){cu_dqp_i[DQP_W-1]}}, cu_dqp_i};
      sum     = $signed({3'b000, pred_eff}) + d_ext;
      wrapped = sum;
      if (sum < 0)
         wrapped = sum + MOD_S;
      else if (sum > MAX_S)
         wrapped = sum - MOD_S;
      qp_new = wrapped[QP_W-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode: accept a CU, divide until the remainder drops below
   // six, then wait for the quant datapath to take the result.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cu_hs) state_nxt = CALC;
         CALC:    if (rem < SIX) state_nxt = OUT;
         OUT:     if (out_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Predictor, QP result, subtract-by-six divider and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred      <= '0;
         rem       <= '0;
         qp_o      <= '0;
         qp_div_o  <= '0;
         qp_mod_o  <= '0;
         dqp_err_o <= 1'b0;
      end else begin
         dqp_err_o <= cu_hs & cu_dqp_en_i & ~dqp_ok;
         if (cu_hs) begin
            pred     <= qp_new;
            qp_o     <= qp_new;
            rem      <= qp_new;
            qp_div_o <= '0;
         end else if (slice_start_i) begin
            pred <= slice_clamped;
         end
         if (state == CALC) begin
            if (rem >= SIX) begin
               rem      <= rem - SIX;
               qp_div_o <= qp_div_o + 4'd1;
            end else begin
               qp_mod_o <= rem[2:0];
            end
         end
      end
   end

   // Delivered-QP counter; a slice start restarts it, counting an output
   // handshake that lands in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cu_cnt_o <= '0;
      else if (slice_start_i)
         cu_cnt_o <= out_hs ? CNT_W'(1) : '0;
      else if (out_hs)
         cu_cnt_o <= cu_cnt_o + CNT_W'(1);
   end

endmodule

// File: tb/tb_tq_qp_ctrl.sv
// tb_tq_qp_ctrl: directed self-checking bench for tq_qp_ctrl.
module tb_tq_qp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        slice_start_i;
   logic [5:0]  slice_qp_i;
   logic        cu_valid_i;
   logic        cu_ready_o;
   logic        cu_dqp_en_i;
   logic [6:0]  cu_dqp_i;
   logic        qp_valid_o;
   logic        qp_ready_i;
   logic [5:0]  qp_o;
   logic [3:0]  qp_div_o;
   logic [2:0]  qp_mod_o;
   logic        dqp_err_o;
   logic        busy_o;
   logic [15:0] cu_cnt_o;

   int checkCount = 0;
   int errorCount = 0;
   int expCnt     = 0;

   tq_qp_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .slice_start_i (slice_start_i),
      .slice_qp_i    (slice_qp_i),
      .cu_valid_i    (cu_valid_i),
      .cu_ready_o    (cu_ready_o),
      .cu_dqp_en_i   (cu_dqp_en_i),
      .cu_dqp_i      (cu_dqp_i),
      .qp_valid_o    (qp_valid_o),
      .qp_ready_i    (qp_ready_i),
      .qp_o          (qp_o),
      .qp_div_o      (qp_div_o),
      .qp_mod_o      (qp_mod_o),
      .dqp_err_o     (dqp_err_o),
      .busy_o        (busy_o),
      .cu_cnt_o      (cu_cnt_o)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One clock step, leaving the bench 1ns past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic loadSlice(input int q);
      slice_start_i = 1'b1;
      slice_qp_i    = 6'(q);
      step();
      slice_start_i = 1'b0;
      expCnt        = 0;
   endtask

   task automatic releaseOutput(input bit withSlice, input int sqp);
      qp_ready_i    = 1'b1;
      slice_start_i = withSlice;
      slice_qp_i    = 6'(sqp);
      step();
      qp_ready_i    = 1'b0;
      slice_start_i = 1'b0;
      expCnt        = withSlice ? 1 : expCnt + 1;
      checkOutput("ready_after_out", int'(cu_ready_o), 1);
      checkOutput("valid_after_out", int'(qp_valid_o), 0);
      checkOutput("cu_cnt", int'(cu_cnt_o), expCnt);
   endtask

   // Issue one CU, measure latency to qp_valid_o and check the result.
   task automatic applyStimulus(input bit en, input int dqp, input bit ss, input int sqp,
                                input int expQp, input int expLat, input bit expErr,
                                input bit doRelease);
      int lat;
      int errPulses;
      checkOutput("ready_before_cu", int'(cu_ready_o), 1);
      cu_valid_i    = 1'b1;
      cu_dqp_en_i   = en;
      cu_dqp_i      = dqp[6:0];
      slice_start_i = ss;
      slice_qp_i    = 6'(sqp);
      step();
      cu_valid_i    = 1'b0;
      cu_dqp_en_i   = 1'b0;
      slice_start_i = 1'b0;
      if (ss) expCnt = 0;
      lat       = 1;
      errPulses = int'(dqp_err_o);
      checkOutput("dqp_err_t1", int'(dqp_err_o), int'(expErr));
      while (!qp_valid_o && lat < 40) begin
         step();
         lat++;
         errPulses += int'(dqp_err_o);
      end
      checkOutput("err_pulses", errPulses, int'(expErr));
      checkOutput("latency", lat, expLat);
      checkOutput("qp", int'(qp_o), expQp);
      checkOutput("div", int'(qp_div_o), expQp / 6);
      checkOutput("mod", int'(qp_mod_o), expQp % 6);
      if (doRelease) releaseOutput(1'b0, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_valid"}, int'(qp_valid_o), 0);
      checkOutput({tag, "_qp"},    int'(qp_o), 0);
      checkOutput({tag, "_div"},   int'(qp_div_o), 0);
      checkOutput({tag, "_mod"},   int'(qp_mod_o), 0);
      checkOutput({tag, "_cnt"},   int'(cu_cnt_o), 0);
      checkOutput({tag, "_err"},   int'(dqp_err_o), 0);
      checkOutput({tag, "_busy"},  int'(busy_o), 0);
   endtask

   initial begin
      bit qpStable;
      bit validHeld;
      bit readyLow;
      int validSeen;

      rst_n = 1'b0; slice_start_i = 1'b0; slice_qp_i = '0;
      cu_valid_i = 1'b0; cu_dqp_en_i = 1'b0; cu_dqp_i = '0; qp_ready_i = 1'b0;
      step(); step();
      checkResetValues("reset");
      rst_n = 1'b1;
      step();
      checkOutput("ready_after_reset", int'(cu_ready_o), 1);

      $display("[TB] basic CU, slice QP 30");
      loadSlice(30);
      applyStimulus(1'b0, 0, 1'b0, 0, 30, 7, 1'b0, 1'b1);

      $display("[TB] positive wrap and predictor carry");
      loadSlice(50);
      applyStimulus(1'b1, 5, 1'b0, 0, 3, 2, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 0, 3, 2, 1'b0, 1'b1);

      $display("[TB] negative wrap");
      loadSlice(2);
      applyStimulus(1'b1, -5, 1'b0, 0, 49, 10, 1'b0, 1'b1);

      $display("[TB] sweep slice QP 0..51");
      for (int q = 0; q <= 51; q++) begin
         loadSlice(q);
         applyStimulus(1'b0, 0, 1'b0, 0, q, q / 6 + 2, 1'b0, 1'b1);
      end

      $display("[TB] backpressure hold");
      loadSlice(20);
      applyStimulus(1'b0, 0, 1'b0, 0, 20, 5, 1'b0, 1'b0);
      qpStable = 1'b1; validHeld = 1'b1; readyLow = 1'b1;
      cu_valid_i = 1'b1; cu_dqp_en_i = 1'b1; cu_dqp_i = 7'd10;
      for (int i = 0; i < 20; i++) begin
         step();
         if (qp_o != 6'd20 || qp_div_o != 4'd3 || qp_mod_o != 3'd2) qpStable = 1'b0;
         if (!qp_valid_o) validHeld = 1'b0;
         if (cu_ready_o) readyLow = 1'b0;
      end
      cu_valid_i = 1'b0; cu_dqp_en_i = 1'b0; cu_dqp_i = '0;
      checkOutput("hold_stable", int'(qpStable), 1);
      checkOutput("hold_valid", int'(validHeld), 1);
      checkOutput("hold_ready_low", int'(readyLow), 1);
      checkOutput("hold_cnt", int'(cu_cnt_o), 0);
      releaseOutput(1'b1, 20);

      $display("[TB] out-of-range delta");
      loadSlice(20);
      applyStimulus(1'b1, -30, 1'b0, 0, 20, 5, 1'b1, 1'b1);
      applyStimulus(1'b1, 26, 1'b0, 0, 20, 5, 1'b1, 1'b1);
      applyStimulus(1'b1, -26, 1'b0, 0, 46, 9, 1'b0, 1'b1);

      $display("[TB] slice start coincident with CU, clamped");
      loadSlice(10);
      applyStimulus(1'b0, 0, 1'b1, 60, 51, 10, 1'b0, 1'b1);

      $display("[TB] reset during CALC");
      loadSlice(48);
      cu_valid_i = 1'b1;
      step();
      cu_valid_i = 1'b0;
      step(); step();
      checkOutput("busy_in_calc", int'(busy_o), 1);
      #2 rst_n = 1'b0;
      #1;
      checkResetValues("mid_reset");
      step();
      rst_n = 1'b1;
      validSeen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         validSeen += int'(qp_valid_o);
      end
      checkOutput("no_valid_after_abort", validSeen, 0);
      expCnt = 0;
      applyStimulus(1'b0, 0, 1'b0, 0, 0, 2, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
